// File: rtl/demod_segment_scheduler_if.sv
// Handshake and data bundle between the segment scheduler, its sample source,
// the shared demodulation slice and the frame consumer.
interface demod_segment_scheduler_if #(
    parameter int NUM_SEG = 10,
    parameter int DW      = 32
);
    logic               start;
    logic               in_valid;
    logic [DW-1:0]      in_sample;
    logic               in_ready;
    logic               slice_req;
    logic [3:0]         slice_idx;
    logic [DW-1:0]      slice_in;
    logic [DW-1:0]      slice_out;
    logic [NUM_SEG-1:0] frame_bits;
    logic               frame_err;
    logic               valid;
    logic               busy;

    // Sample handshake: a sample transfers in any cycle where in_valid and in_ready are both 1.
    modport slave (
        input  start, in_valid, in_sample, slice_out,
        output in_ready, slice_req, slice_idx, slice_in, frame_bits, frame_err, valid, busy
    );

    modport master (
        output start, in_valid, in_sample, slice_out,
        input  in_ready, slice_req, slice_idx, slice_in, frame_bits, frame_err, valid, busy
    );
endinterface

// File: rtl/demod_segment_scheduler.sv
// Feeds NUM_SEG samples of a frame through a shared fixed-latency demod slice,
// collects the hard decisions into a packed word and flags illegal decisions.
module demod_segment_scheduler #(
    parameter int NUM_SEG = 10,
    parameter int LAT     = 2,
    parameter int DW      = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    demod_segment_scheduler_if.slave bus,
    output logic [1:0]               dbg_state_o
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [DW-1:0] POS_ONE = {{(DW-17){1'b0}}, 1'b1, 16'h0000};
    localparam logic [DW-1:0] NEG_ONE = {{(DW-16){1'b1}}, 16'h0000};

    state_t                  state_q;
    logic [4:0]              iss_cnt_q;
    logic [4:0]              ret_cnt_q;
    logic [LAT-1:0]          sr_req_q;
    logic [LAT-1:0][3:0]     sr_idx_q;
    logic [NUM_SEG-1:0]      frame_bits_q;
    logic                    frame_err_q;
    logic                    valid_q;
    logic                    busy_q;

    logic                    in_ready;
    logic                    accept;
    logic                    ret_fire;
    logic [3:0]              ret_idx;
    logic                    ret_legal;

    // Gated by reset so a mid-frame reset cycle cannot issue to the slice.
    assign in_ready  = (state_q == FEED) && !reset;
    assign accept    = bus.in_valid && in_ready;
    assign ret_fire  = sr_req_q[LAT-1];
    assign ret_idx   = sr_idx_q[LAT-1];
    assign ret_legal = (bus.slice_out == POS_ONE) || (bus.slice_out == NEG_ONE);

    assign bus.in_ready   = in_ready;
    assign bus.slice_req  = accept;
    assign bus.slice_idx  = accept ? iss_cnt_q[3:0] : 4'd0;
    assign bus.slice_in   = accept ? bus.in_sample : '0;
    assign bus.frame_bits = frame_bits_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.valid      = valid_q;
    assign bus.busy       = busy_q;
    assign dbg_state_o    = state_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            iss_cnt_q    <= '0;
            ret_cnt_q    <= '0;
            sr_req_q     <= '0;
            sr_idx_q     <= '0;
            frame_bits_q <= '0;
            frame_err_q  <= 1'b0;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            valid_q     <= 1'b0;
            sr_req_q[0] <= accept;
            sr_idx_q[0] <= iss_cnt_q[3:0];
            for (int i = 1; i < LAT; i++) begin
                sr_req_q[i] <= sr_req_q[i-1];
                sr_idx_q[i] <= sr_idx_q[i-1];
            end

            // The decision bit always follows the sign, even when the value is illegal.
            if (ret_fire) begin
                for (int k = 0; k < NUM_SEG; k++) begin
                    if (ret_idx == 4'(k)) frame_bits_q[k] <= ~bus.slice_out[DW-1];
                end
                ret_cnt_q <= ret_cnt_q + 5'd1;
                if (!ret_legal) frame_err_q <= 1'b1;
            end

            case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state_q      <= FEED;
                        busy_q       <= 1'b1;
                        iss_cnt_q    <= '0;
                        ret_cnt_q    <= '0;
                        frame_bits_q <= '0;
                        frame_err_q  <= 1'b0;
                    end else if (state_q == DONE) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                FEED: begin
                    if (accept) begin
                        iss_cnt_q <= iss_cnt_q + 5'd1;
                        if (iss_cnt_q == 5'(NUM_SEG-1)) state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (ret_fire && (ret_cnt_q == 5'(NUM_SEG-1))) begin
                        state_q <= DONE;
                        valid_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_demod_segment_scheduler.sv
// Randomized bench for demod_segment_scheduler: a slice model with fixed latency,
// a frame-level reference model feeding a result queue, and a valid monitor.
module tb_demod_segment_scheduler;
    localparam int NUM_SEG = 10;
    localparam int LAT     = 2;
    localparam int DW      = 32;
    localparam int EW      = NUM_SEG + 1 + 32;
    localparam logic [DW-1:0] POS = 32'h0001_0000;
    localparam logic [DW-1:0] NEG = 32'hFFFF_0000;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] dbg_state;
    int         cyc = 0;

    demod_segment_scheduler_if #(.NUM_SEG(NUM_SEG), .DW(DW)) bus ();

    demod_segment_scheduler #(.NUM_SEG(NUM_SEG), .LAT(LAT), .DW(DW)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int                 vectors = 0;
    int                 miscompares = 0;
    logic [EW-1:0]      exp_q[$];
    logic [DW-1:0]      pipe_q[$];
    logic [DW-1:0]      smp[NUM_SEG];
    bit                 cor_en[NUM_SEG];
    logic [DW-1:0]      cor_val[NUM_SEG];
    bit                 exp_issue;
    int                 exp_idx;
    logic [DW-1:0]      exp_smp;
    logic [NUM_SEG-1:0] last_bits;
    logic               last_err;
    logic [EW-1:0]      mon_e;
    logic [DW-1:0]      dec;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Slice behaviour: sign decision unless this segment is set to return a forced value.
    function automatic logic [DW-1:0] slice_decide(input logic [3:0] idx, input logic [DW-1:0] s);
        if (int'(idx) < NUM_SEG && cor_en[idx]) return cor_val[idx];
        return s[DW-1] ? NEG : POS;
    endfunction

    // ---------------- slice model + issue checker ----------------
    always @(negedge clk) begin
        #2;
        check("slice_req", 64'(bus.slice_req), 64'(exp_issue));
        if (bus.slice_req) begin
            check("slice_idx", 64'(bus.slice_idx), 64'(exp_idx));
            check("slice_in", 64'(bus.slice_in), 64'(exp_smp));
        end else begin
            check("idle_slice_idx", 64'(bus.slice_idx), 64'd0);
            check("idle_slice_in", 64'(bus.slice_in), 64'd0);
        end
        bus.slice_out = pipe_q.pop_front();
        dec = bus.slice_req ? slice_decide(bus.slice_idx, bus.slice_in) : '0;
        pipe_q.push_back(dec);
    end

    // ---------------- result monitor ----------------
    always @(negedge clk) begin
        #3;
        if (bus.valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 64'd1, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("frame_bits", 64'(bus.frame_bits), 64'(mon_e[EW-1 -: NUM_SEG]));
                check("frame_err", 64'(bus.frame_err), 64'(mon_e[32]));
                check("valid_cycle", 64'(cyc), 64'(mon_e[31:0]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_quiet(input bit st);
        @(negedge clk);
        bus.start     = st;
        bus.in_valid  = 1'($urandom_range(0, 1));
        bus.in_sample = $urandom;
        exp_issue     = 1'b0;
    endtask

    task automatic setup_alt();
        for (int k = 0; k < NUM_SEG; k++) begin
            smp[k]    = (k % 2 == 0) ? 32'h0002_0000 : 32'hFFFE_0000;
            cor_en[k] = 1'b0;
            cor_val[k] = '0;
        end
    endtask

    task automatic setup_rand();
        for (int k = 0; k < NUM_SEG; k++) begin
            smp[k]     = $urandom;
            cor_en[k]  = ($urandom_range(0, 7) == 0);
            cor_val[k] = ($urandom_range(0, 1) == 1) ? (($urandom_range(0, 1) == 1) ? POS : NEG) : $urandom;
        end
    endtask

    task automatic run_frame(input bit b2b_in, input int gap_at, input int gap_len, input int stall_pct,
                             input bit pulse_start, input int abort_at, input bit b2b_next);
        int start_cyc, done_cyc, k, stalls, gap_left;
        bit gap;
        logic [NUM_SEG-1:0] eb;
        logic ee;
        if (b2b_in) begin
            start_cyc = cyc;
        end else begin
            drive_quiet(1'b1);
            start_cyc = cyc;
            #1;
            check("hold_bits", 64'(bus.frame_bits), 64'(last_bits));
            check("hold_err", 64'(bus.frame_err), 64'(last_err));
            check("idle_busy", 64'(bus.busy), 64'd0);
        end
        k = 0;
        stalls = 0;
        gap_left = gap_len;
        while (k < NUM_SEG) begin
            @(negedge clk);
            bus.start = pulse_start ? 1'($urandom_range(0, 1)) : 1'b0;
            if (abort_at >= 0 && cyc - start_cyc == abort_at) begin
                reset        = 1'b1;
                bus.in_valid = 1'b1;
                exp_issue    = 1'b0;
                #1 check("rst_in_ready", 64'(bus.in_ready), 64'd0);
                @(negedge clk);
                reset        = 1'b0;
                bus.start    = 1'b0;
                bus.in_valid = 1'b0;
                #1;
                check("rst_busy", 64'(bus.busy), 64'd0);
                check("rst_bits", 64'(bus.frame_bits), 64'd0);
                check("rst_err", 64'(bus.frame_err), 64'd0);
                check("rst_valid", 64'(bus.valid), 64'd0);
                for (int i = 0; i < LAT + 2; i++) begin
                    drive_quiet(1'b0);
                    #1;
                    check("late_ret_bits", 64'(bus.frame_bits), 64'd0);
                    check("late_ret_busy", 64'(bus.busy), 64'd0);
                end
                last_bits = '0;
                last_err  = 1'b0;
                return;
            end
            gap = (k == gap_at) && (gap_left > 0);
            if (gap || (stalls < 20 && $urandom_range(0, 99) < stall_pct)) begin
                bus.in_valid  = 1'b0;
                bus.in_sample = $urandom;
                exp_issue     = 1'b0;
                stalls++;
                if (gap) gap_left--;
            end else begin
                bus.in_valid  = 1'b1;
                bus.in_sample = smp[k];
                exp_issue     = 1'b1;
                exp_idx       = k;
                exp_smp       = smp[k];
                k++;
            end
            #1;
            check("feed_in_ready", 64'(bus.in_ready), 64'd1);
            check("feed_busy", 64'(bus.busy), 64'd1);
        end
        // Reference: bit k is the sign of whatever the slice returns for segment k.
        ee = 1'b0;
        for (int j = 0; j < NUM_SEG; j++) begin
            eb[j] = cor_en[j] ? ~cor_val[j][DW-1] : ~smp[j][DW-1];
            if (cor_en[j] && cor_val[j] != POS && cor_val[j] != NEG) ee = 1'b1;
        end
        done_cyc = start_cyc + NUM_SEG + stalls + LAT + 1;
        exp_q.push_back({eb, ee, 32'(done_cyc)});
        last_bits = eb;
        last_err  = ee;
        while (cyc + 1 < done_cyc) begin
            @(negedge clk);
            bus.start     = pulse_start ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.in_sample = $urandom;
            exp_issue     = 1'b0;
            #1;
            check("drain_in_ready", 64'(bus.in_ready), 64'd0);
            check("drain_busy", 64'(bus.busy), 64'd1);
        end
        drive_quiet(b2b_next);
        #1 check("done_busy", 64'(bus.busy), 64'd1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bit b2b, nb;
        reset         = 1'b1;
        bus.start     = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_sample = '0;
        bus.slice_out = '0;
        exp_issue     = 1'b0;
        exp_idx       = 0;
        exp_smp       = '0;
        last_bits     = '0;
        last_err      = 1'b0;
        for (int i = 0; i < LAT; i++) pipe_q.push_back('0);

        repeat (3) @(negedge clk);
        #1;
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_in_ready", 64'(bus.in_ready), 64'd0);
        check("reset_valid", 64'(bus.valid), 64'd0);
        check("reset_bits", 64'(bus.frame_bits), 64'd0);
        check("reset_err", 64'(bus.frame_err), 64'd0);
        @(negedge clk);
        reset     = 1'b0;
        bus.start = 1'b0;
        #1 check("reset_over_start", 64'(bus.busy), 64'd0);

        setup_alt();                      run_frame(1'b0, -1, 0, 0, 1'b0, -1, 1'b0);
        setup_alt();                      run_frame(1'b0, 4, 3, 0, 1'b0, -1, 1'b0);
        setup_alt(); cor_en[7] = 1'b1;    run_frame(1'b0, -1, 0, 0, 1'b0, -1, 1'b0);
        drive_quiet(1'b0);
        setup_alt();                      run_frame(1'b0, -1, 0, 0, 1'b0, 6, 1'b0);
        setup_alt();                      run_frame(1'b0, -1, 0, 0, 1'b0, -1, 1'b0);
        setup_rand();                     run_frame(1'b0, -1, 0, 0, 1'b0, -1, 1'b1);
        setup_rand();                     run_frame(1'b1, -1, 0, 0, 1'b0, -1, 1'b0);
        setup_rand();                     run_frame(1'b0, 2, 2, 20, 1'b1, -1, 1'b0);

        b2b = 1'b0;
        for (int f = 0; f < 25; f++) begin
            nb = (f == 24) ? 1'b0 : 1'($urandom_range(0, 1));
            setup_rand();
            run_frame(b2b, -1, 0, $urandom_range(0, 30), 1'($urandom_range(0, 1)), -1, nb);
            b2b = nb;
            if (!b2b && $urandom_range(0, 1) == 1) drive_quiet(1'b0);
        end

        repeat (LAT + 4) drive_quiet(1'b0);
        check("pending_frames", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/demod_segment_scheduler.md
DEMOD_SEGMENT_SCHEDULER -- requirements
Module: demod_segment_scheduler

Interface
REQ-001 Parameter NUM_SEG, default 10: segments per frame, range 2..16.
REQ-002 Parameter LAT, default 2: fixed slice latency in cycles, range 1..8.
REQ-003 Parameter DW, default 32: sample width, Q16.16 signed.
REQ-004 Port clk  in  1: single clock, rising edge; reset is synchronous and active-high.
REQ-005 Port reset  in  1: synchronous, active-high.
REQ-006 Port start  in  1: one-cycle request to begin a frame.
REQ-007 Port in_valid  in  1: in_sample is valid.
REQ-008 Port in_sample  in  DW: received soft sample.
REQ-009 Port in_ready  out  1: block accepts a sample this cycle.
REQ-010 Port slice_req  out  1: issue strobe to the shared demodulation slice.
REQ-011 Port slice_idx  out  4: segment index of the issued sample.
REQ-012 Port slice_in  out  DW: sample forwarded to the slice.
REQ-013 Port slice_out  in  DW: slice decision, +1.0 (0x00010000) or -1.0 (0xFFFF0000).
REQ-014 Port frame_bits  out  NUM_SEG: packed decisions; bit k belongs to segment k.
REQ-015 Port frame_err  out  1: at least one decision in the frame was illegal.
REQ-016 Port valid  out  1: one-cycle strobe; frame_bits and frame_err are valid.
REQ-017 Port busy  out  1: a frame is in progress.

Function
REQ-018 FSM states are IDLE, FEED, DRAIN and DONE; all state is registered on clk.
REQ-019 IDLE: start=1 goes to FEED next cycle; the issue count, return count, frame_bits and frame_err clear on the same edge.
REQ-020 FEED: in_ready=1; accept = in_valid & in_ready.
REQ-021 On accept, combinationally in the same cycle: slice_req=1, slice_in=in_sample, slice_idx=issue count.
REQ-022 When slice_req=0, slice_idx and slice_in shall be 0.
REQ-023 Issue count increments on each accept; it resets to 0 when a new frame starts.
REQ-024 FEED: in_valid=0 stalls the FSM with no timeout, and no issue occurs.
REQ-025 The accept that carries index NUM_SEG-1 moves the FSM to DRAIN next cycle; in_ready=0 in every state except FEED.
REQ-026 Return tracking: a LAT-deep shift register holds {req, idx}; an issue at cycle t returns at cycle t+LAT, and slice_out is sampled at the end of that cycle.
REQ-027 On each return: frame_bits[idx] <= ~slice_out[31], and the return count increments.
REQ-028 On each return where slice_out is neither 0x00010000 nor 0xFFFF0000: frame_err <= 1 (sticky for the frame), and the bit is still taken from the sign.
REQ-029 DRAIN goes to DONE on the cycle after the return count reaches NUM_SEG.
REQ-030 DONE: valid=1 for exactly one cycle, then IDLE.
REQ-031 DONE with start=1 goes directly to FEED (back-to-back frames); the clears of REQ-019 apply.
REQ-032 start is ignored in FEED and DRAIN.
REQ-033 busy=1 in FEED, DRAIN and DONE; busy=0 in IDLE.
REQ-034 frame_bits and frame_err hold their value from DONE until the next frame start.
REQ-035 Latency, with one sample per cycle: start at cycle 0; samples at cycles 1..NUM_SEG; valid at cycle NUM_SEG+LAT+1.

Reset
REQ-036 reset=1 forces IDLE and clears the issue count, return count and return shift register.
REQ-037 reset=1 drives frame_bits=0, frame_err=0, valid=0, busy=0, in_ready=0 and slice_req=0.
REQ-038 Reset mid-frame discards in-flight returns; slice_out arriving after reset does not change frame_bits.
REQ-039 reset has priority over start when both are asserted in the same cycle.

Verification
REQ-040 Nominal frame: defaults; start, then 10 samples alternating +0x00020000/-0x00020000 with slice model LAT=2 -> valid=1 at cycle 13, frame_bits=0x155, frame_err=0.
REQ-041 Stall: in_valid deasserted for 3 cycles after sample 4 -> in_ready stays 1, no slice_req during the gap; valid at cycle 16, same frame_bits.
REQ-042 Illegal decision: slice model returns 0x00000000 for segment 7 -> frame_err=1, frame_bits[7]=1.
REQ-043 Reset mid-frame: reset at cycle 6 -> IDLE next cycle, busy=0, frame_bits=0, late returns ignored; a following frame completes correctly.
REQ-044 Back-to-back: start held at 1 during DONE -> FEED next cycle, second valid NUM_SEG+LAT+1 cycles after the first.
REQ-045 Ignored start: start pulsed during FEED and DRAIN -> no state, count or output change.
